// File: rtl/ysyx_24070016_ifu_fetch.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a req/gnt +
// rvalid memory handshake and hands instructions to decode via valid/ready.
// Redirects override every event except in IDLE; a redirect that races an
// in-flight fetch marks the pending response for discard (kill).
module ysyx_24070016_ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_plus4;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4     = pc_q + XLEN'(4);

  // Outputs depend on registered state only; no input-to-output paths.
  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      kill_q    <= kill_d;
    end
  end

  // Next-state and datapath update; redirect is checked first in every busy state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    kill_d    = kill_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // A grant in the same cycle launched a fetch of the old address.
          if (imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24070016_ifu_fetch.sv
// Self-checking bench for the fetch stage: a behavioural memory with random
// grant/latency, directed scenarios, and a randomized run checked against an
// architectural PC-stream model.
module tb_ysyx_24070016_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0;
  int errors = 0;

  // memory model knobs
  int unsigned gnt_pct   = 100;
  int unsigned noise_pct = 0;
  int unsigned mem_lat   = 0;
  bit          lat_rand  = 1'b0;
  int unsigned lat_max   = 0;
  bit          force_en  = 1'b0;
  logic [31:0] force_data = '0;
  bit          mem_busy  = 1'b0;
  int unsigned mem_cnt   = 0;
  logic [31:0] mem_resp  = '0;

  ysyx_24070016_ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_1F2E;
  endfunction

  // Memory: one outstanding request, response 1+lat cycles after grant.
  initial begin : mem_proc
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_resp; mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if (imem_req) begin
        if ($urandom_range(99) < gnt_pct) begin
          imem_gnt = 1'b1; mem_busy = 1'b1;
          mem_cnt  = lat_rand ? $urandom_range(lat_max) : mem_lat;
          mem_resp = force_en ? force_data : mem_word(imem_addr);
        end
      end else if ($urandom_range(99) < noise_pct) begin
        imem_gnt = 1'($urandom); imem_rvalid = 1'($urandom);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (inst_pc !== RESET_PC) begin errors++; $display("FAIL reset_inst_pc got %h want %h", inst_pc, RESET_PC); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
    rst = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_latency();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    int          cy  [3];
    int          n = 0;
    gnt_pct = 100; mem_lat = 0; lat_rand = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      if (inst_valid) begin pcs[n] = inst_pc; ins[n] = inst; cy[n] = i; n++; end
      tick();
    end
    checks++; if (n != 3) begin errors++; $display("FAIL zl_count got %0d want 3", n); end
    for (int k = 0; k < n; k++) begin
      checks++; if (pcs[k] !== RESET_PC + 32'(4 * k)) begin
        errors++; $display("FAIL zl_pc%0d got %h want %h", k, pcs[k], RESET_PC + 32'(4 * k));
      end
      checks++; if (ins[k] !== mem_word(RESET_PC + 32'(4 * k))) begin
        errors++; $display("FAIL zl_inst%0d got %h want %h", k, ins[k], mem_word(RESET_PC + 32'(4 * k)));
      end
      if (k > 0) begin
        checks++; if (cy[k] - cy[k-1] != 3) begin
          errors++; $display("FAIL zl_spacing%0d got %0d want 3", k, cy[k] - cy[k-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h_inst, h_pc;
    int n = 0;
    inst_ready = 1'b0;
    while (!inst_valid && n < 40) begin tick(); n++; end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_wait got %0b want 1", inst_valid); end
    h_inst = inst; h_pc = inst_pc;
    checks++; if (h_pc !== RESET_PC + 32'hC || h_inst !== mem_word(RESET_PC + 32'hC)) begin
      errors++; $display("FAIL bp_first got pc=%h inst=%h want pc=%h inst=%h", h_pc, h_inst, RESET_PC + 32'hC, mem_word(RESET_PC + 32'hC));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst !== h_inst || inst_pc !== h_pc || imem_req !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%0b inst=%h pc=%h req=%0b want v=1 inst=%h pc=%h req=0",
                           i, inst_valid, inst, inst_pc, imem_req, h_inst, h_pc);
      end
    end
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    checks++; if (imem_req !== 1'b1 || imem_addr !== h_pc + 32'd4) begin
      errors++; $display("FAIL bp_next_addr got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, h_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    bit seen_valid = 1'b0;
    inst_ready = 1'b1; mem_lat = 2; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    while (!(imem_req && imem_gnt) && n < 40) begin tick(); n++; end
    checks++; if (!(imem_req && imem_gnt)) begin errors++; $display("FAIL rw_grant got 0 want 1"); end
    tick();
    force_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      if (inst_valid) seen_valid = 1'b1;
      tick(); n++;
    end
    checks++; if (seen_valid) begin errors++; $display("FAIL rw_no_valid got 1 want 0"); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000) begin
      errors++; $display("FAIL rw_next_addr got req=%0b addr=%h want req=1 addr=80001000", imem_req, imem_addr);
    end
    mem_lat = 0; inst_ready = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_1000 || inst !== mem_word(32'h8000_1000)) begin
      errors++; $display("FAIL rw_deliver got v=%0b pc=%h inst=%h want v=1 pc=80001000 inst=%h",
                         inst_valid, inst_pc, inst, mem_word(32'h8000_1000));
    end
  endtask

  task automatic test_redirect_hold();
    int n = 0;
    inst_ready = 1'b0;
    while (!inst_valid && n < 40) begin tick(); n++; end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_2000) begin
      errors++; $display("FAIL rh_next got v=%0b req=%0b addr=%h want v=0 req=1 addr=80002000", inst_valid, imem_req, imem_addr);
    end
    n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    checks++; if (inst_pc !== 32'h8000_2000 || inst !== mem_word(32'h8000_2000)) begin
      errors++; $display("FAIL rh_deliver got pc=%h inst=%h want pc=80002000 inst=%h", inst_pc, inst, mem_word(32'h8000_2000));
    end
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!inst_valid && n < 30) begin tick(); n++; end
    checks++; if (inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_deliver got pc=%h inst=%h want pc=fffffffc inst=%h", inst_pc, inst, mem_word(32'hFFFF_FFFC));
    end
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    bit seen_valid = 1'b0;
    inst_ready = 1'b1; mem_lat = 3;
    while (!(imem_req && imem_gnt) && n < 40) begin tick(); n++; end
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
                  inst_pc !== RESET_PC || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rmw_async got req=%0b v=%0b inst=%h pc=%h addr=%h want 0 0 0 %h %h",
                         imem_req, inst_valid, inst, inst_pc, imem_addr, RESET_PC, RESET_PC);
    end
    tick();
    rst = 1'b1;
    mem_lat = 0;
    n = 0;
    while (!(imem_req && imem_gnt) && n < 30) begin
      if (inst_valid) seen_valid = 1'b1;
      tick(); n++;
    end
    checks++; if (seen_valid) begin errors++; $display("FAIL rmw_stale_valid got 1 want 0"); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rmw_restart got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    checks++; if (inst_pc !== RESET_PC || inst !== mem_word(RESET_PC)) begin
      errors++; $display("FAIL rmw_deliver got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  // Architectural model: expected fetch PC advances by 4 per consumed
  // instruction and jumps to the aligned target on any redirect.
  task automatic test_random();
    logic [31:0] exp_pc = '0;
    bit          have_pc = 1'b0;
    int          delivered = 0;
    logic [31:0] tgt;
    gnt_pct = 60; lat_rand = 1'b1; lat_max = 3; noise_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      tick();
      inst_ready     = ($urandom_range(99) < 70);
      redirect_valid = (i == 0) || ($urandom_range(99) < 5);
      tgt            = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      redirect_pc    = tgt;
      if (have_pc && imem_req) begin
        checks++; if (imem_addr !== exp_pc) begin
          errors++; $display("FAIL rnd_addr cyc%0d got %h want %h", i, imem_addr, exp_pc);
        end
      end
      if (inst_valid) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_in_hold cyc%0d got 1 want 0", i); end
      end
      if (redirect_valid) begin
        exp_pc  = {tgt[31:2], 2'b00};
        have_pc = 1'b1;
      end else if (inst_valid && inst_ready && have_pc) begin
        checks++; if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rnd_deliver cyc%0d got pc=%h inst=%h want pc=%h inst=%h", i, inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    redirect_valid = 1'b0;
    checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress got %0d want >=50", delivered); end
  endtask

  initial begin : main
    test_reset();
    test_zero_latency();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
